// File: rtl/dbgnoc_na_input.sv
// Receive-side debug NoC network adapter: buffers incoming flits in a
// first-word-fall-through FIFO and exposes them through a single-cycle-ack bus slave.
module dbgnoc_na_input #(
   parameter int NOC_DATA_WIDTH = 16,
   parameter int NOC_TYPE_WIDTH = 2,
   parameter int ADDRESS_WIDTH  = 32,
   parameter int fifo_depth     = 16
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [NOC_DATA_WIDTH+NOC_TYPE_WIDTH-1:0] noc_in_flit,
   input  logic                                     noc_in_valid,
   output logic                                     noc_in_ready,
   input  logic [ADDRESS_WIDTH-1:0]                 bus_addr,
   input  logic                                     bus_we,
   input  logic                                     bus_en,
   input  logic [NOC_DATA_WIDTH-1:0]                bus_data_in,
   output logic [NOC_DATA_WIDTH-1:0]                bus_data_out,
   output logic                                     bus_ack,
   output logic                                     irq
);

   localparam int FLIT_W     = NOC_DATA_WIDTH + NOC_TYPE_WIDTH;
   localparam int size_width = $clog2(fifo_depth + 1);
   localparam int PTR_W      = $clog2(fifo_depth);

   localparam logic [1:0] REG_DATA    = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_COUNT   = 2'd2;
   localparam logic [1:0] REG_CONTROL = 2'd3;

   logic [FLIT_W-1:0]         mem [fifo_depth];
   logic [PTR_W-1:0]          rd_ptr, wr_ptr;
   logic [size_width-1:0]     fill, pkt_cnt, pkt_cnt_next;
   logic                      irq_en, in_enable;
   logic                      empty, full, access, wr_ctrl, flush;
   logic                      push, pop, push_last, pop_last;
   logic [FLIT_W-1:0]         head;
   logic                      head_first, head_last;
   logic [NOC_DATA_WIDTH-1:0] rdata;
   logic                      unused_bits;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(fifo_depth - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   function automatic logic [7:0] sat8(input logic [size_width-1:0] v);
      logic [size_width+7:0] w;
      w = {8'b0, v};
      return (w > (size_width+8)'(255)) ? 8'hFF : w[7:0];
   endfunction

   assign empty   = (fill == '0);
   assign full    = (fill == size_width'(fifo_depth));
   assign access  = bus_en & ~bus_ack;
   assign wr_ctrl = access & bus_we & (bus_addr[3:2] == REG_CONTROL);
   assign flush   = wr_ctrl & bus_data_in[0];

   // Ready is withheld during the flush cycle so no flit slips in behind the clear.
   assign noc_in_ready = in_enable & ~full & ~flush;
   assign push         = noc_in_valid & noc_in_ready;
   assign pop          = access & ~bus_we & (bus_addr[3:2] == REG_DATA) & ~empty;

   assign head       = mem[rd_ptr];
   assign head_first = ~empty & head[NOC_DATA_WIDTH+1];
   assign head_last  = ~empty & head[NOC_DATA_WIDTH];
   assign push_last  = push & noc_in_flit[NOC_DATA_WIDTH];
   assign pop_last   = pop & head_last;

   assign unused_bits = ^{bus_addr[ADDRESS_WIDTH-1:4], bus_addr[1:0],
                          bus_data_in[NOC_DATA_WIDTH-1:2]};

   always_comb begin
      pkt_cnt_next = pkt_cnt;
      if (flush)
         pkt_cnt_next = '0;
      else if (push_last && !pop_last)
         pkt_cnt_next = pkt_cnt + size_width'(1);
      else if (!push_last && pop_last)
         pkt_cnt_next = pkt_cnt - size_width'(1);
   end

   always_comb begin
      rdata = '0;
      case (bus_addr[3:2])
         REG_DATA:    rdata = empty ? '0 : head[NOC_DATA_WIDTH-1:0];
         REG_STATUS:  rdata = NOC_DATA_WIDTH'({sat8(pkt_cnt), 4'b0, head_last, head_first,
                                               empty, (pkt_cnt != '0)});
         REG_COUNT:   rdata = NOC_DATA_WIDTH'(fill);
         REG_CONTROL: rdata = NOC_DATA_WIDTH'({irq_en, 1'b0});
         default:     rdata = '0;
      endcase
   end

   // Flit storage carries no reset; validity is tracked by the pointers and fill level.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= noc_in_flit;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_enable    <= 1'b0;
         bus_ack      <= 1'b0;
         bus_data_out <= '0;
         irq_en       <= 1'b0;
         irq          <= 1'b0;
         pkt_cnt      <= '0;
         fill         <= '0;
         rd_ptr       <= '0;
         wr_ptr       <= '0;
      end else begin
         in_enable    <= 1'b1;
         bus_ack      <= bus_en & ~bus_ack;
         bus_data_out <= (access & ~bus_we) ? rdata : '0;
         if (wr_ctrl)
            irq_en <= bus_data_in[1];
         irq     <= irq_en & (pkt_cnt_next != '0);
         pkt_cnt <= pkt_cnt_next;
         if (flush) begin
            fill   <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push)
               wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
               rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)
               fill <= fill + size_width'(1);
            else if (!push && pop)
               fill <= fill - size_width'(1);
         end
      end
   end

endmodule
